// File: rtl/biss_pos_tracker.sv
// BiSS-C position tracker: unwraps single-turn samples into a multiturn count,
// produces a per-frame signed delta, rejects implausible jumps and flags stale links.
module biss_pos_tracker #(
    parameter int POS_W      = 24,
    parameter int TURN_W     = 16,
    parameter int JUMP_MAX   = 1048576,
    parameter int STALE_CLKS = 5000000,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      scd_valid,
    input  logic [POS_W-1:0]          scd_pos,
    input  logic                      scd_nerr,
    input  logic                      scd_nwarn,
    input  logic                      crc_ok,
    output logic                      pos_valid,
    output logic [TURN_W-1:0]         turns,
    output logic [TURN_W+POS_W-1:0]   pos_mt,
    output logic [POS_W:0]            delta,
    output logic                      warn,
    output logic                      locked,
    output logic                      jump_err,
    output logic                      stale,
    output logic [CNT_W-1:0]          frame_cnt,
    output logic [CNT_W-1:0]          err_cnt
);

    localparam int WD_W = $clog2(STALE_CLKS + 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(STALE_CLKS - 1);
    localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(STALE_CLKS);
    localparam logic [POS_W:0]   JUMP_LIM = (POS_W+1)'(JUMP_MAX);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   locked_s;

    logic [WD_W-1:0]        wd_r;
    logic [POS_W-1:0]       prev_r;
    logic [TURN_W-1:0]      turns_r;
    logic [POS_W:0]         delta_r;
    logic                   warn_r;
    logic                   pos_valid_r;
    logic                   jump_err_r;
    logic                   stale_r;
    logic [CNT_W-1:0]       frame_cnt_r;
    logic [CNT_W-1:0]       err_cnt_r;

    logic [POS_W-1:0]       diff_s;
    logic [POS_W:0]         d_s;
    logic [POS_W:0]         mag_s;
    logic                   jump_s;
    logic                   good_s;
    logic                   bad_s;
    logic                   in_track_s;
    logic                   accept_s;
    logic                   jump_rej_s;
    logic                   reject_s;
    logic                   expire_s;
    logic [TURN_W-1:0]      turns_nxt_s;
    logic [POS_W:0]         delta_nxt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // Signed wrapped difference and its magnitude; one extra bit keeps -2^(POS_W-1) representable
    always_comb begin
        diff_s = scd_pos - prev_r;
        d_s    = {diff_s[POS_W-1], diff_s};
        if (d_s[POS_W]) begin
            mag_s = {(POS_W+1){1'b0}} - d_s;
        end else begin
            mag_s = d_s;
        end
        jump_s = (mag_s > JUMP_LIM);
    end

    // Sample classification; clr swallows any coincident sample
    always_comb begin
        in_track_s = (state_r == ST_TRACK);
        good_s     = scd_valid & crc_ok & scd_nerr & ~clr;
        bad_s      = scd_valid & ~(crc_ok & scd_nerr) & ~clr;
        accept_s   = good_s & (~in_track_s | ~jump_s);
        jump_rej_s = good_s & in_track_s & jump_s;
        reject_s   = bad_s | jump_rej_s;
        expire_s   = ~clr & ~scd_valid & (wd_r == WD_LAST);
    end

    // Turn unwrapping and delta for an accepted sample
    always_comb begin
        turns_nxt_s = turns_r;
        delta_nxt_s = {(POS_W+1){1'b0}};
        if (in_track_s) begin
            delta_nxt_s = d_s;
            if (!d_s[POS_W] && (scd_pos < prev_r)) begin
                turns_nxt_s = turns_r + TURN_W'(1);
            end else if (d_s[POS_W] && (scd_pos > prev_r)) begin
                turns_nxt_s = turns_r - TURN_W'(1);
            end else begin
                turns_nxt_s = turns_r;
            end
        end else begin
            delta_nxt_s = {(POS_W+1){1'b0}};
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        if (clr) begin
            state_nxt_s = ST_INIT;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (accept_s) begin
                        state_nxt_s = ST_TRACK;
                    end else begin
                        state_nxt_s = ST_INIT;
                    end
                end
                ST_TRACK: begin
                    if (expire_s) begin
                        state_nxt_s = ST_INIT;
                    end else begin
                        state_nxt_s = ST_TRACK;
                    end
                end
                default: state_nxt_s = ST_INIT;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        locked_s = 1'b0;
        case (state_r)
            ST_INIT:  locked_s = 1'b0;
            ST_TRACK: locked_s = 1'b1;
            default:  locked_s = 1'b0;
        endcase
    end

    // Link watchdog: restarts on any sample, holds once expired
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_r <= {WD_W{1'b0}};
        end else if (clr || scd_valid) begin
            wd_r <= {WD_W{1'b0}};
        end else if (wd_r != WD_LIM) begin
            wd_r <= wd_r + WD_W'(1);
        end else begin
            wd_r <= wd_r;
        end
    end

    // Position, turns, delta and warning of the last accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r  <= {POS_W{1'b0}};
            turns_r <= {TURN_W{1'b0}};
            delta_r <= {(POS_W+1){1'b0}};
            warn_r  <= 1'b0;
        end else if (clr) begin
            turns_r <= {TURN_W{1'b0}};
            delta_r <= {(POS_W+1){1'b0}};
        end else if (accept_s) begin
            prev_r  <= scd_pos;
            turns_r <= turns_nxt_s;
            delta_r <= delta_nxt_s;
            warn_r  <= ~scd_nwarn;
        end
    end

    // Output strobe and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_valid_r <= 1'b0;
            jump_err_r  <= 1'b0;
            stale_r     <= 1'b0;
        end else if (clr) begin
            pos_valid_r <= 1'b0;
            jump_err_r  <= 1'b0;
            stale_r     <= 1'b0;
        end else begin
            pos_valid_r <= accept_s;
            if (jump_rej_s) begin
                jump_err_r <= 1'b1;
            end
            if (accept_s) begin
                stale_r <= 1'b0;
            end else if (expire_s) begin
                stale_r <= 1'b1;
            end
        end
    end

    // Saturating frame and error counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
        end else if (clr) begin
            frame_cnt_r <= {CNT_W{1'b0}};
            err_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                frame_cnt_r <= sat_inc(frame_cnt_r);
            end
            if (reject_s) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign pos_valid = pos_valid_r;
    assign turns     = turns_r;
    assign pos_mt    = {turns_r, prev_r};
    assign delta     = delta_r;
    assign warn      = warn_r;
    assign locked    = locked_s;
    assign jump_err  = jump_err_r;
    assign stale     = stale_r;
    assign frame_cnt = frame_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: doc/biss_pos_tracker.md
Name: biss_pos_tracker

Overview:
- Consumes validated BiSS-C single-cycle-data samples (24-bit singleturn position, active-low error/warning bits, CRC6 result) from the BiSS master.
- Unwraps the position into a signed multiturn count and produces a per-frame signed delta (velocity proxy).
- Rejects implausible jumps and flags stale links.
- Feeds the UART streaming/HEX display path with a clean, monotonic-aware position word.

Parameters:
POS_W, 24, singleturn position width (bits)
TURN_W, 16, signed turn counter width; wraps modulo 2^TURN_W
JUMP_MAX, 1048576, max accepted |delta| per frame in counts (2^20 = 1/16 rev)
STALE_CLKS, 5000000, clk cycles without scd_valid before stale (100 ms at 50 MHz)
CNT_W, 16, width of frame/error counters (saturating)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of counters, sticky flags, turns; forces INIT
scd_valid  in  1  one-cycle strobe, new sample; already in clk domain
scd_pos  in  POS_W  singleturn position, MSB first as received
scd_nerr  in  1  BiSS error bit, active-low
scd_nwarn  in  1  BiSS warning bit, active-low
crc_ok  in  1  CRC6 check passed for this sample
pos_valid  out  1  one-cycle strobe, outputs updated
turns  out  TURN_W  signed turn count
pos_mt  out  TURN_W+POS_W  {turns, position}
delta  out  POS_W+1  signed position change since last accepted sample
warn  out  1  warning bit of last accepted sample, active-high
locked  out  1  1 in TRACK state
jump_err  out  1  sticky: a sample was rejected for |delta| > JUMP_MAX
stale  out  1  level: watchdog expired, cleared by next accepted sample
frame_cnt  out  CNT_W  accepted samples, saturating
err_cnt  out  CNT_W  rejected samples (CRC, nerr, jump), saturating

Behaviour:
- Reset (rst_n low, async): all outputs 0, state INIT, prev position 0, watchdog 0.
- Sample is good when scd_valid & crc_ok & scd_nerr. Otherwise, a scd_valid sample increments err_cnt; no other output changes; no pos_valid.
- Latency: outputs and pos_valid are registered exactly 1 clk after the scd_valid cycle.
- State INIT, on a good sample:
  - prev <= scd_pos; delta <= 0; turns unchanged (0 after reset/clr).
  - State goes to TRACK; locked=1; pos_valid; frame_cnt++.
- State TRACK, on a good sample:
  - d = (scd_pos - prev) mod 2^POS_W, interpreted as POS_W-bit signed, sign-extended to POS_W+1.
  - Magnitude is computed in POS_W+1 bits, so d = -2^(POS_W-1) gives magnitude 2^(POS_W-1) with no overflow.
  - If |d| > JUMP_MAX: reject. Set jump_err, err_cnt++, no pos_valid, prev/turns held.
  - Else accept:
    - If d >= 0 and scd_pos < prev: turns+1.
    - If d < 0 and scd_pos > prev: turns-1.
    - Turns wrap modulo 2^TURN_W.
    - prev <= scd_pos; delta <= d; warn <= ~scd_nwarn; stale <= 0; pos_valid; frame_cnt++.
- pos_mt is {turns, prev} after update.
- Watchdog:
  - Counts clk cycles and resets to 0 on every scd_valid (good or bad).
  - When it reaches STALE_CLKS: stale=1, state to INIT, locked=0, counter holds.
  - Turns are kept across re-acquisition. delta on the re-acquire sample = 0.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr has priority over a simultaneous scd_valid: the sample is dropped and not counted. clr zeroes turns, delta, counters, jump_err, stale, and the watchdog, and sets state INIT.
- Reset mid-sample: a pending pos_valid is cancelled.
- No back-pressure: the consumer must take pos_valid in that cycle.

Test Plan:
- Reset, then good sample pos=0x000100 -> 1 clk later: pos_valid=1, locked=1, delta=0, turns=0, frame_cnt=1.
- Forward wrap: prev=0xFFFF00, good pos=0x000080 -> delta=+0x180, turns=1, pos_mt=0x0001_000080.
- Reverse wrap: prev=0x000010, good pos=0xFFFFF0 -> delta=-0x20 (25'h1FFFFE0), turns=0xFFFF.
- Jump: prev=0x000000, pos=0x200000 (> 2^20) -> no pos_valid, jump_err=1, err_cnt+1, turns/prev unchanged.
- Then pos=0x0FFFFF is accepted (|d| <= JUMP_MAX).
- Bad samples: crc_ok=0 with pos=0x123456 -> err_cnt+1, outputs unchanged. Then scd_nerr=0 -> err_cnt+1 again. Then scd_nwarn=0 on a good sample -> warn=1.
- Watchdog and clr: no scd_valid for STALE_CLKS cycles -> stale=1, locked=0. Next good sample -> stale=0, locked=1, delta=0, turns preserved. clr asserted together with scd_valid -> sample dropped; all counters 0, turns 0, state INIT.
